// File: rtl/core_bus_bridge.sv
// Valid/ready bus responder for a peripheral core register block: one-hot strobes and registered irq.
// Optional CORE_BUS_BRIDGE_READ_PIPE_EN adds a WAIT state so read data is sampled one cycle after the strobe.
module core_bus_bridge #(
    parameter int unsigned REGS   = 3,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [31:0]          core_data_in,
    output logic [REGS-1:0]      core_write_en,
    output logic [REGS-1:0]      core_read_en,
    input  logic [32*REGS-1:0]   core_data_out,
    input  logic                 core_irq,
    output logic                 irq_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                in_range;
    logic                capture;
    logic                sample_rd;
    logic [31:0]         rd_word;

    // Full-width compare so upper address bits never alias onto valid registers.
    assign in_range  = 32'(req_addr) < REGS;
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign capture   = req_ready && req_valid;

`ifdef CORE_BUS_BRIDGE_READ_PIPE_EN
    assign sample_rd = (state_q == StWait) && !write_q;
`else
    assign sample_rd = (state_q == StAccess) && !write_q;
`endif

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < REGS; i++) begin
            if (32'(addr_q) == i) rd_word = core_data_out[32*i +: 32];
        end
    end

    always_comb begin
        core_write_en = '0;
        core_read_en  = '0;
        if (state_q == StAccess) begin
            for (int unsigned i = 0; i < REGS; i++) begin
                if (32'(addr_q) == i) begin
                    core_write_en[i] = write_q;
                    core_read_en[i]  = !write_q;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) state_d = in_range ? StAccess : StResp;
            end
`ifdef CORE_BUS_BRIDGE_READ_PIPE_EN
            StAccess: state_d = StWait;
            StWait:   state_d = StResp;
`else
            StAccess: state_d = StResp;
`endif
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            addr_q       <= '0;
            core_data_in <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            irq_out      <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_out <= core_irq;
            if (capture) begin
                write_q      <= req_write;
                addr_q       <= req_addr;
                core_data_in <= req_wdata;
                rsp_rdata    <= '0;
                rsp_err      <= !in_range;
            end else if (sample_rd) begin
                rsp_rdata <= rd_word;
            end
        end
    end

endmodule

// File: doc/core_bus_bridge.md
Name: core_bus_bridge

Overview:
- Bus-side responder for a peripheral core register block: accepts single-beat read/write requests from a bus master over a valid/ready channel and decodes the word address.
- Drives the core's per-register write_en/read_en strobes and data_in; returns the selected data_out word on a valid/ready response channel.
- Registers the core's irq line for the host.
- Sits between the system interconnect and one peripheral core instance.

Parameters:
- REGS, 3, number of core registers (word-addressed 0..REGS-1)
- ADDR_W, 4, request address width in bits; must satisfy 2**ADDR_W >= REGS

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  bridge can accept request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  master accepts response
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  address out of range
- core_data_in  output  32  write data to core
- core_write_en  output  REGS  one-hot write strobe, bit i = register i
- core_read_en  output  REGS  one-hot read strobe
- core_data_out  input  32*REGS  core register words, register i at bits [32*i+31:32*i]
- core_irq  input  1  core interrupt request
- irq_out  output  1  registered interrupt to host

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low on reset_n; all flops clear immediately on reset_n low.
- Reset values: state IDLE; rsp_valid 0; rsp_rdata 0; rsp_err 0; core_data_in 0; core_write_en 0; core_read_en 0; irq_out 0. req_ready is 1 once reset_n is high.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid && req_ready at a rising edge) captures write, addr and wdata.
  - wdata goes to core_data_in, which holds until the next capture.
  - addr < REGS: go to ACCESS.
  - addr >= REGS: go to RESP with rsp_err = 1, rsp_rdata = 0. No strobe is ever issued.
- ACCESS:
  - Exactly one cycle; req_ready = 0.
  - core_write_en[addr] = 1 for a write; core_read_en[addr] = 1 for a read. All other strobe bits are 0.
  - On a read, rsp_rdata is loaded at the end of the cycle from core_data_out word [addr]. This returns the pre-update value of any register the core changes on that edge.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; req_ready = 0.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
  - rsp_rdata and rsp_err are cleared when the next request is captured.
- Latency:
  - Request accepted at edge N; strobe high during cycle N+1; rsp_valid high from edge N+2.
  - Minimum of 3 cycles per transaction.
  - A new request can be accepted in the cycle after the response handshake.
- Strobes are combinationally decoded from state and captured addr only; they are glitch-free because both are registered.
- Read data for a write is 0; rsp_err for an in-range access is 0.
- Back-pressure: rsp_ready low holds RESP indefinitely. No request is accepted while in RESP.
- irq_out = core_irq delayed one clk; no latching or masking.
- Reset mid-transaction:
  - Return to IDLE immediately and drop any strobe in the same instant.
  - The pending response is discarded; the master must reissue.
- Boundary addresses:
  - addr = REGS-1 is valid; addr = REGS is an error.
  - Upper address bits above the decode range participate in the range check; there is no aliasing.

Optional Feature:
- Macro: CORE_BUS_BRIDGE_READ_PIPE_EN
- When defined:
  - Adds state WAIT between ACCESS and RESP.
  - Read data is sampled at the end of WAIT, one cycle after the strobe, to support cores with registered read paths.
  - The sampled value reflects any update made at the strobe edge.
  - rsp_valid rises at N+3 for all in-range accesses.
  - Error responses still skip ACCESS and WAIT.
- When undefined: three-state FSM and latency exactly as above.

Test Plan:
- Write addr 1, wdata 0x0000_0005 -> core_write_en = 3'b010 for exactly one cycle at N+1; core_data_in = 0x5; rsp_valid at N+2 with rdata 0, err 0.
- Read addr 0 with core word 0 = 0x1234_5678, rsp_ready held low 4 cycles -> core_read_en = 3'b001 for one cycle; rsp_valid held with rdata 0x1234_5678 stable until rsp_ready; req_ready low throughout.
- Read addr 3 (REGS = 3) -> no strobe asserted; rsp_valid at N+1 with err 1, rdata 0.
- Assert reset_n low during ACCESS of a write -> strobe drops immediately; no response after reset release; req_ready = 1.
- Toggle core_irq 0->1->0 over 3 cycles -> irq_out follows with exactly one cycle delay.
- With CORE_BUS_BRIDGE_READ_PIPE_EN and a core word that increments on every edge from 100 -> read returns 101 (without the macro: 100); rsp_valid at N+3.
